fetch_sequencer: RTL and testbench

Parametrised fetch-stage PC sequencer for the pipelined RISC-V core. It replaces the fixed two-cycle conditional-jump stall counter with a handshake-based branch-resolution wait and an external pipeline hold. It also adds machine-mode interrupt entry and mret return. It drives the instruction-memory word index and the decode-enable flag, and sits between instruction memory, the decoder and the executer.

---
 rtl/fetch_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage PC sequencer with handshake branch-resolution
// wait, external pipeline hold, machine-mode interrupt entry and mret return.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined;
// otherwise STALL_CYCLES and REDIRECTS are tied to zero.
module fetch_sequencer #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             STALL,
  input  logic             BRANCH_IN_DECODE,
  input  logic             RESOLVE_VALID,
  input  logic [XLEN-1:0]  RESOLVE_NEXT_PC,
  input  logic             RESOLVE_MRET,
  input  logic             INTERRUPT,
  input  logic [XLEN-1:0]  MTVEC,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  DECODE_PC,
  output logic             DECODE_ENABLE,
  output logic             IN_TRAP,
  output logic [XLEN-1:0]  MEPC,
  output logic [CNT_W-1:0] STALL_CYCLES,
  output logic [CNT_W-1:0] REDIRECTS
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   decode_pc_q, decode_pc_d;
  logic              decode_enable_q, decode_enable_d;
  logic              in_trap_q, in_trap_d;
  logic [XLEN-1:0]   mepc_q, mepc_d;
  logic              take_irq_c;
  logic              accept_resolve_c;

  // Redirect events shared by the sequencer and the counters
  assign take_irq_c       = (state_q == ST_RUN) && !STALL && INTERRUPT &&
                            !in_trap_q && decode_enable_q;
  assign accept_resolve_c = (state_q == ST_WAIT) && RESOLVE_VALID;

  // Next-state and next-PC selection
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    decode_pc_d     = decode_pc_q;
    decode_enable_d = decode_enable_q;
    in_trap_d       = in_trap_q;
    mepc_d          = mepc_q;
    case (state_q)
      ST_RUN: begin
        if (take_irq_c) begin
          // Squash the instruction in decode; it is re-executed after mret
          mepc_d          = decode_pc_q;
          pc_d            = MTVEC;
          in_trap_d       = 1'b1;
          decode_enable_d = 1'b0;
          state_d         = ST_REFILL;
        end else if (!STALL && BRANCH_IN_DECODE && decode_enable_q) begin
          pc_d            = pc_q + XLEN'(1);
          decode_pc_d     = pc_q;
          decode_enable_d = 1'b0;
          state_d         = ST_WAIT;
        end else if (!STALL) begin
          pc_d            = pc_q + XLEN'(1);
          decode_pc_d     = pc_q;
          decode_enable_d = 1'b1;
        end
      end
      ST_WAIT: begin
        decode_enable_d = 1'b0;
        // Resolution is accepted even under STALL so the executer never re-sends
        if (accept_resolve_c) begin
          pc_d    = RESOLVE_MRET ? mepc_q : RESOLVE_NEXT_PC;
          state_d = ST_REFILL;
          if (RESOLVE_MRET) begin
            in_trap_d = 1'b0;
          end
        end
      end
      ST_REFILL: begin
        if (!STALL) begin
          pc_d            = pc_q + XLEN'(1);
          decode_pc_d     = pc_q;
          decode_enable_d = 1'b1;
          state_d         = ST_RUN;
        end
      end
      default: begin
        state_d         = ST_REFILL;
        decode_enable_d = 1'b0;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q         <= ST_REFILL;
      pc_q            <= XLEN'(RESET_PC);
      decode_pc_q     <= '0;
      decode_enable_q <= 1'b0;
      in_trap_q       <= 1'b0;
      mepc_q          <= '0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      decode_pc_q     <= decode_pc_d;
      decode_enable_q <= decode_enable_d;
      in_trap_q       <= in_trap_d;
      mepc_q          <= mepc_d;
    end
  end

  assign PC            = pc_q;
  assign DECODE_PC     = decode_pc_q;
  assign DECODE_ENABLE = decode_enable_q;
  assign IN_TRAP       = in_trap_q;
  assign MEPC          = mepc_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] redirects_q, redirects_d;

  // Saturating counters: cycles spent waiting and redirects taken
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    redirects_d    = redirects_q;
    if ((state_q == ST_WAIT) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
    if ((accept_resolve_c || take_irq_c) && (redirects_q != '1)) begin
      redirects_d = redirects_q + CNT_W'(1);
    end
  end

  // Counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cycles_q <= '0;
      redirects_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      redirects_q    <= redirects_d;
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
  assign REDIRECTS    = redirects_q;
`else
  assign STALL_CYCLES = '0;
  assign REDIRECTS    = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset, sequential fetch, branch wait,
// interrupt entry/mret, deferred interrupt, STALL behaviour, wrap and async reset.
module tb_fetch_sequencer;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RST;
  logic             STALL;
  logic             BRANCH_IN_DECODE;
  logic             RESOLVE_VALID;
  logic [XLEN-1:0]  RESOLVE_NEXT_PC;
  logic             RESOLVE_MRET;
  logic             INTERRUPT;
  logic [XLEN-1:0]  MTVEC;
  logic [XLEN-1:0]  PC;
  logic [XLEN-1:0]  DECODE_PC;
  logic             DECODE_ENABLE;
  logic             IN_TRAP;
  logic [XLEN-1:0]  MEPC;
  logic [CNT_W-1:0] STALL_CYCLES;
  logic [CNT_W-1:0] REDIRECTS;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.XLEN(XLEN), .RESET_PC(0), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BRANCH_IN_DECODE(BRANCH_IN_DECODE),
    .RESOLVE_VALID(RESOLVE_VALID), .RESOLVE_NEXT_PC(RESOLVE_NEXT_PC),
    .RESOLVE_MRET(RESOLVE_MRET), .INTERRUPT(INTERRUPT), .MTVEC(MTVEC),
    .PC(PC), .DECODE_PC(DECODE_PC), .DECODE_ENABLE(DECODE_ENABLE),
    .IN_TRAP(IN_TRAP), .MEPC(MEPC), .STALL_CYCLES(STALL_CYCLES), .REDIRECTS(REDIRECTS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_fetch(input string tag, input logic [XLEN-1:0] pc,
                           input logic [XLEN-1:0] dpc, input logic de);
    chk({tag, ".pc"}, 64'(PC), 64'(pc));
    chk({tag, ".dpc"}, 64'(DECODE_PC), 64'(dpc));
    chk({tag, ".de"}, 64'(DECODE_ENABLE), 64'(de));
  endtask

  task automatic chk_cnt(input string tag, input int sc, input int rd);
    chk({tag, ".stall_cycles"}, 64'(STALL_CYCLES), PERF ? 64'(sc) : 64'd0);
    chk({tag, ".redirects"}, 64'(REDIRECTS), PERF ? 64'(rd) : 64'd0);
  endtask

  initial begin
    RST = 1'b1; STALL = 1'b0; BRANCH_IN_DECODE = 1'b0; RESOLVE_VALID = 1'b0;
    RESOLVE_NEXT_PC = '0; RESOLVE_MRET = 1'b0; INTERRUPT = 1'b0; MTVEC = '0;
    repeat (2) step();
    chk_fetch("reset", 0, 0, 1'b0);
    chk("reset.in_trap", 64'(IN_TRAP), 64'd0);
    chk("reset.mepc", 64'(MEPC), 64'd0);
    chk_cnt("reset", 0, 0);

    // Sequential fetch after reset release
    RST = 1'b0;
    step(); chk_fetch("seq1", 1, 0, 1'b1);
    step(); chk_fetch("seq2", 2, 1, 1'b1);
    step(); chk_fetch("seq3", 3, 2, 1'b1);
    step(); step();
    chk_fetch("seq5", 5, 4, 1'b1);

    // STALL held 4 cycles in RUN
    STALL = 1'b1;
    repeat (4) step();
    chk_fetch("stall_run", 5, 4, 1'b1);
    STALL = 1'b0;

    // Branch at DECODE_PC=9, resolve two cycles later to 12
    repeat (5) step();
    chk_fetch("pre_branch", 10, 9, 1'b1);
    BRANCH_IN_DECODE = 1'b1;
    step(); chk_fetch("br_wait1", 11, 10, 1'b0);
    BRANCH_IN_DECODE = 1'b0;
    step(); chk_fetch("br_wait2", 11, 10, 1'b0);
    RESOLVE_VALID = 1'b1; RESOLVE_NEXT_PC = 12;
    step(); chk("br_refill.pc", 64'(PC), 64'd12);
    chk("br_refill.de", 64'(DECODE_ENABLE), 64'd0);
    RESOLVE_VALID = 1'b0;
    step(); chk_fetch("br_target", 13, 12, 1'b1);
    chk_cnt("br", 2, 1);

    // Interrupt at DECODE_PC=20, MTVEC=36; held high to check no nesting
    repeat (8) step();
    chk_fetch("pre_irq", 21, 20, 1'b1);
    INTERRUPT = 1'b1; MTVEC = 36;
    step();
    chk("irq.mepc", 64'(MEPC), 64'd20);
    chk("irq.in_trap", 64'(IN_TRAP), 64'd1);
    chk("irq.pc", 64'(PC), 64'd36);
    chk("irq.de", 64'(DECODE_ENABLE), 64'd0);
    step(); chk_fetch("irq_handler", 37, 36, 1'b1);
    step(); chk_fetch("irq_no_nest", 38, 37, 1'b1);
    chk("irq_no_nest.mepc", 64'(MEPC), 64'd20);
    chk_cnt("irq", 2, 2);

    // mret from the handler; INTERRUPT still held through WAIT/REFILL
    BRANCH_IN_DECODE = 1'b1;
    step(); chk_fetch("mret_wait", 39, 38, 1'b0);
    BRANCH_IN_DECODE = 1'b0;
    RESOLVE_VALID = 1'b1; RESOLVE_MRET = 1'b1; RESOLVE_NEXT_PC = 99;
    step();
    chk("mret.pc", 64'(PC), 64'd20);
    chk("mret.in_trap", 64'(IN_TRAP), 64'd0);
    RESOLVE_VALID = 1'b0; RESOLVE_MRET = 1'b0;
    step(); chk_fetch("mret_ret", 21, 20, 1'b1);
    chk("mret_ret.in_trap", 64'(IN_TRAP), 64'd0);
    // Held request is taken in the first RUN cycle
    step();
    chk("irq2.pc", 64'(PC), 64'd36);
    chk("irq2.in_trap", 64'(IN_TRAP), 64'd1);
    chk("irq2.mepc", 64'(MEPC), 64'd20);
    INTERRUPT = 1'b0;
    step(); chk_fetch("irq2_handler", 37, 36, 1'b1);

    // mret accepted while STALL is high; REFILL then holds under STALL
    BRANCH_IN_DECODE = 1'b1;
    step(); chk_fetch("smret_wait", 38, 37, 1'b0);
    BRANCH_IN_DECODE = 1'b0;
    RESOLVE_VALID = 1'b1; RESOLVE_MRET = 1'b1; STALL = 1'b1;
    step();
    chk("smret.pc", 64'(PC), 64'd20);
    chk("smret.in_trap", 64'(IN_TRAP), 64'd0);
    RESOLVE_VALID = 1'b0; RESOLVE_MRET = 1'b0;
    step(); chk_fetch("smret_hold", 20, 37, 1'b0);
    STALL = 1'b0;
    step(); chk_fetch("smret_ret", 21, 20, 1'b1);
    chk_cnt("smret", 4, 5);

    // Interrupt raised during WAIT is deferred until RUN
    BRANCH_IN_DECODE = 1'b1;
    step(); chk_fetch("dwait1", 22, 21, 1'b0);
    BRANCH_IN_DECODE = 1'b0; INTERRUPT = 1'b1;
    step();
    chk("dwait2.pc", 64'(PC), 64'd22);
    chk("dwait2.in_trap", 64'(IN_TRAP), 64'd0);
    RESOLVE_VALID = 1'b1; RESOLVE_NEXT_PC = 50;
    step(); chk("dres.pc", 64'(PC), 64'd50);
    RESOLVE_VALID = 1'b0;
    step(); chk_fetch("drefill", 51, 50, 1'b1);
    chk("drefill.in_trap", 64'(IN_TRAP), 64'd0);
    step();
    chk("dirq.pc", 64'(PC), 64'd36);
    chk("dirq.mepc", 64'(MEPC), 64'd50);
    chk("dirq.in_trap", 64'(IN_TRAP), 64'd1);
    chk_cnt("dirq", 6, 7);
    INTERRUPT = 1'b0;
    step(); chk_fetch("dirq_handler", 37, 36, 1'b1);

    // Async reset mid-WAIT with STALL_CYCLES=7
    BRANCH_IN_DECODE = 1'b1;
    step();
    BRANCH_IN_DECODE = 1'b0;
    step(); chk_fetch("rwait", 38, 37, 1'b0);
    chk_cnt("rwait", 7, 7);
    RST = 1'b1;
    #1;
    chk_fetch("async_rst", 0, 0, 1'b0);
    chk("async_rst.in_trap", 64'(IN_TRAP), 64'd0);
    chk("async_rst.mepc", 64'(MEPC), 64'd0);
    chk_cnt("async_rst", 0, 0);
    RESOLVE_VALID = 1'b1; RESOLVE_NEXT_PC = 77;
    step();
    RST = 1'b0;
    step(); chk_fetch("stale_resolve", 1, 0, 1'b1);
    RESOLVE_VALID = 1'b0;

    // PC wrap from all-ones
    BRANCH_IN_DECODE = 1'b1;
    step();
    BRANCH_IN_DECODE = 1'b0;
    RESOLVE_VALID = 1'b1; RESOLVE_NEXT_PC = '1;
    step(); chk("wrap_set.pc", 64'(PC), 64'hFFFF_FFFF);
    RESOLVE_VALID = 1'b0;
    step(); chk_fetch("wrap", 0, 32'hFFFF_FFFF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
